// File: rtl/fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param_if
// Brief    : Handshake, threshold, data and status bundle for fifo_param.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_param_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W:0]   sup_Threshold;
    logic [ADDR_W:0]   inf_Threshold;
    logic              clear_err;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              empty;
    logic              full;
    logic              alm_empty;
    logic              alm_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, data_in, sup_Threshold, inf_Threshold, clear_err,
        input  data_out, valid_out, empty, full, alm_empty, alm_full,
               count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, sup_Threshold, inf_Threshold, clear_err,
        output data_out, valid_out, empty, full, alm_empty, alm_full,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param
// Brief    : Synchronous FIFO with occupancy thresholds, sticky error flags
//            and selectable registered or first-word-fall-through read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3,
    parameter int FWFT   = 0
) (
    input  wire logic     clk,
    input  wire logic     reset_L,
    fifo_param_if.slave   bus
);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(2**ADDR_W);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    // Pop never bypasses: an empty FIFO refuses it even alongside a push.
    assign w_pop_ok  = bus.pop && !w_empty;
    assign w_push_ok = bus.push && (!w_full || w_pop_ok);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + (ADDR_W+1)'(1);
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - (ADDR_W+1)'(1);
            // A fresh error wins over a same-cycle clear.
            r_overflow  <= (r_overflow && !bus.clear_err) || (bus.push && !w_push_ok);
            r_underflow <= (r_underflow && !bus.clear_err) || (bus.pop && w_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out  = r_mem[r_rd_ptr];
            assign bus.valid_out = !w_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] r_dout;
            logic              r_valid;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_pop_ok;
                    if (w_pop_ok) r_dout <= r_mem[r_rd_ptr];
                end
            end
            assign bus.data_out  = r_dout;
            assign bus.valid_out = r_valid;
        end
    endgenerate

    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.alm_full  = (r_count >= bus.sup_Threshold);
    assign bus.alm_empty = (r_count <= bus.inf_Threshold);
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_param
// Brief    : Scoreboard bench driving a registered-read and an FWFT FIFO
//            with identical stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;
    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_L;
    logic          push, pop, clear_err;
    logic [DW-1:0] data_in;
    logic [AW:0]   sup_th, inf_th;

    fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.push = push;          assign bus1.push = push;
    assign bus0.pop = pop;            assign bus1.pop = pop;
    assign bus0.data_in = data_in;    assign bus1.data_in = data_in;
    assign bus0.clear_err = clear_err; assign bus1.clear_err = clear_err;
    assign bus0.sup_Threshold = sup_th; assign bus1.sup_Threshold = sup_th;
    assign bus0.inf_Threshold = inf_th; assign bus1.inf_Threshold = inf_th;

    fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) dut0 (
        .clk(clk), .reset_L(reset_L), .bus(bus0));
    fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) dut1 (
        .clk(clk), .reset_L(reset_L), .bus(bus1));

    // Reference model: stored words, words popped awaiting display, flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp0[$];
    bit            m_ovf, m_unf, m_vexp;
    logic [DW-1:0] m_last;
    int            n_chk, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp0.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_vexp = 1'b0;
        m_last = '0;
    endtask

    task automatic step(input bit p, input bit r, input logic [DW-1:0] d, input bit c);
        bit pop_ok, push_ok;
        int sz;
        @(negedge clk);
        #1;
        push = p; pop = r; data_in = d; clear_err = c;
        @(posedge clk);
        sz      = q.size();
        pop_ok  = r && (sz > 0);
        push_ok = p && ((sz < DEPTH) || pop_ok);
        if (pop_ok)  exp0.push_back(q.pop_front());
        if (push_ok) q.push_back(d);
        m_ovf  = (m_ovf && !c) || (p && !push_ok);
        m_unf  = (m_unf && !c) || (r && (sz == 0));
        m_vexp = pop_ok;
    endtask

    // Monitor: compares both DUTs against the model once per cycle.
    always @(negedge clk) begin
        int sz;
        sz = q.size();
        chk("count",     32'(bus0.count),     32'(sz));
        chk("empty",     32'(bus0.empty),     32'(sz == 0));
        chk("full",      32'(bus0.full),      32'(sz == DEPTH));
        chk("alm_full",  32'(bus0.alm_full),  32'(sz >= int'(sup_th)));
        chk("alm_empty", 32'(bus0.alm_empty), 32'(sz <= int'(inf_th)));
        chk("overflow",  32'(bus0.overflow),  32'(m_ovf));
        chk("underflow", 32'(bus0.underflow), 32'(m_unf));
        chk("valid_out", 32'(bus0.valid_out), 32'(m_vexp));
        if (m_vexp && exp0.size() > 0) m_last = exp0.pop_front();
        m_vexp = 1'b0;
        chk("data_out",  32'(bus0.data_out),  32'(m_last));
        chk("fwft_count", 32'(bus1.count),    32'(sz));
        chk("fwft_ovf",  32'(bus1.overflow),  32'(m_ovf));
        chk("fwft_unf",  32'(bus1.underflow), 32'(m_unf));
        chk("fwft_valid", 32'(bus1.valid_out), 32'(sz > 0));
        if (sz > 0) chk("fwft_data", 32'(bus1.data_out), 32'(q[0]));
    end

    initial begin
        n_chk = 0; n_fail = 0;
        model_reset();
        reset_L = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        data_in = '0; sup_th = 4'd6; inf_th = 4'd2;
        repeat (2) @(negedge clk);
        #1 reset_L = 1'b1;

        // Fill to full, then overflow.
        for (int i = 1; i <= 9; i++) step(1, 0, DW'(i), 0);
        // Drain in order, then underflow.
        for (int i = 0; i < 9; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 1);
        // Simultaneous push/pop while full.
        for (int i = 0; i < 8; i++) step(1, 0, DW'(8'h10 + i), 0);
        step(1, 1, 10'h3FF, 0);
        for (int i = 0; i < 9; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 1);
        // Pointer wrap at a steady count of 3.
        for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), 0);
        for (int i = 0; i < 20; i++) step(1, 1, DW'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
        // Fall-through into an empty FIFO.
        step(1, 0, 10'h155, 0);
        step(0, 0, '0, 0);
        step(0, 1, '0, 0);
        step(0, 0, '0, 0);

        // Mid-cycle reset at count 5 with overflow set.
        for (int i = 0; i < 9; i++) step(1, 0, DW'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 0);
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        chk("rst_count", 32'(bus0.count),     32'd0);
        chk("rst_empty", 32'(bus0.empty),     32'd1);
        chk("rst_ovf",   32'(bus0.overflow),  32'd0);
        chk("rst_valid", 32'(bus0.valid_out), 32'd0);
        @(negedge clk);
        #1 reset_L = 1'b1;

        // Clear coinciding with a new overflow keeps the flag.
        for (int i = 0; i < 8; i++) step(1, 0, DW'($urandom), 0);
        step(1, 0, DW'($urandom), 1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0);

        // Randomized traffic with random (including extreme) thresholds.
        for (int i = 0; i < 600; i++) begin
            int bias;
            if (i % 40 == 0) begin
                sup_th = AW'(0) + 4'($urandom_range(0, 15));
                inf_th = 4'($urandom_range(0, 15));
            end
            bias = (i / 100) % 3;
            step($urandom_range(0, 3) < 1 + bias, $urandom_range(0, 3) < 3 - bias,
                 DW'($urandom), $urandom_range(0, 15) == 0);
        end
        sup_th = 4'd0; inf_th = 4'd8;
        step(0, 0, '0, 1);
        for (int i = 0; i < 9; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        chk("sb_drain", 32'(exp0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
